// File: rtl/usb_pd_pkg.sv
// ---------------------------------------------------------------------------
// usb_pd_pkg
// Shared definitions for the USB-PD CC-line front end.
//   cc_sel_t            : which CC channel carries the BMC traffic
//   gap_timeout_cycles  : converts the core clock (kHz) into the maximum
//                         number of idle cycles allowed between two BMC
//                         edges (4 us worth of clocks)
// ---------------------------------------------------------------------------
package usb_pd_pkg;

    typedef enum logic {
        CC_SEL_CC1 = 1'b0,
        CC_SEL_CC2 = 1'b1
    } cc_sel_t;

    // 4 us expressed in core clock cycles: khz * 4e-3 ms = khz / 250.
    function automatic int gap_timeout_cycles(input int clk_khz);
        return clk_khz / 250;
    endfunction

endpackage

// File: rtl/usb_pd_cc_line_cc_chan_det.sv
// ---------------------------------------------------------------------------
// cc_chan_det
// One CC channel of the PD front end: comparator decode, two-flop
// synchronizer, optional glitch filter, edge detection and the BMC activity
// qualifier (gap counter + consecutive-edge counter).
//
// Optional build macro: CC_GLITCH_FILT_EN adds a 3-sample majority filter
// after the synchronizer (one extra cycle of latency, single-cycle pulses
// are rejected).
//
// Ports:
//   clock      in   core clock, rising edge
//   nrst       in   synchronous active-low reset
//   phy_p      in   comparator positive output
//   phy_n      in   comparator negative output
//   det_run    in   detector may count this cycle
//   det_clear  in   clear both counters (re-arm)
//   lvl        out  synchronized (optionally filtered) CC level
//   qualified  out  LOCK_EDGES consecutive in-time edges have been seen
// ---------------------------------------------------------------------------
module cc_chan_det
    import usb_pd_pkg::*;
#(
    parameter int GAP_TIMEOUT = 120,
    parameter int LOCK_EDGES  = 32
) (
    input  logic clock,
    input  logic nrst,
    input  logic phy_p,
    input  logic phy_n,
    input  logic det_run,
    input  logic det_clear,
    output logic lvl,
    output logic qualified
);

    localparam int GAP_W  = $clog2(GAP_TIMEOUT + 2);
    localparam int EDGE_W = $clog2(LOCK_EDGES + 1);

    localparam logic [GAP_W-1:0]  GAP_LIMIT = GAP_W'(GAP_TIMEOUT);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(GAP_TIMEOUT + 1);
    localparam logic [EDGE_W-1:0] EDGE_MAX  = EDGE_W'(LOCK_EDGES);

    logic              raw_q;
    logic              raw_now;
    logic              sync1;
    logic              sync2;
    logic              lvl_prev;
    logic              edge_seen;
    logic [GAP_W-1:0]  gap_cnt;
    logic [EDGE_W-1:0] edge_cnt;

    // A comparator pair that agrees (p == n) is undecided, so the last
    // decided value is kept instead.
    assign raw_now = (phy_p != phy_n) ? phy_p : raw_q;

    // Decode holder plus the two-flop synchronizer chain.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            raw_q <= 1'b0;
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            raw_q <= raw_now;
            sync1 <= raw_now;
            sync2 <= sync1;
        end
    end

`ifdef CC_GLITCH_FILT_EN
    logic sync3;
    logic sync4;

    // Two more samples of the synchronized level feed a majority vote, so
    // a one-cycle spike never wins.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            sync3 <= 1'b0;
            sync4 <= 1'b0;
        end else begin
            sync3 <= sync2;
            sync4 <= sync3;
        end
    end

    assign lvl = (sync2 & sync3) | (sync2 & sync4) | (sync3 & sync4);
`else
    assign lvl = sync2;
`endif

    // Previous level keeps running even while the counters are frozen, so
    // an edge during a freeze is never replayed once counting resumes.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            lvl_prev <= 1'b0;
        end else begin
            lvl_prev <= lvl;
        end
    end

    assign edge_seen = lvl ^ lvl_prev;

    // Gap counter measures cycles since the last edge; edge counter counts
    // edges that arrived within the timeout. A gap that runs past the
    // timeout throws away the accumulated edge run.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            gap_cnt  <= '0;
            edge_cnt <= '0;
        end else if (det_clear) begin
            gap_cnt  <= '0;
            edge_cnt <= '0;
        end else if (det_run) begin
            if (edge_seen) begin
                gap_cnt <= '0;
                if (gap_cnt <= GAP_LIMIT) begin
                    if (edge_cnt != EDGE_MAX) begin
                        edge_cnt <= edge_cnt + EDGE_W'(1);
                    end
                end else begin
                    edge_cnt <= '0;
                end
            end else begin
                if (gap_cnt != GAP_MAX) begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
                if (gap_cnt > GAP_LIMIT) begin
                    edge_cnt <= '0;
                end
            end
        end
    end

    assign qualified = (edge_cnt == EDGE_MAX);

endmodule

// File: rtl/usb_pd_cc_line.sv
// ---------------------------------------------------------------------------
// usb_pd_cc_line
// USB-PD CC-line physical front end. Watches both CC channels for BMC
// traffic, locks onto the active one (cable orientation), forwards its
// level to the BMC reader and steers the BMC writer onto that channel only.
//
// Optional build macro: CC_GLITCH_FILT_EN (majority filter in each channel
// detector, cc_din latency grows from 3 to 4 cycles).
//
// Ports:
//   clock            in   core clock, rising edge
//   nrst             in   synchronous active-low reset
//   cc_check         in   orientation detection request (level)
//   cc_io_ctrl       in   transmitter busy
//   cc_dout          in   BMC bit stream from the writer
//   cc_lock          out  orientation locked
//   cc_din           out  received level from the locked channel
//   phy_in_cc1_p/n   in   CC1 comparator pair
//   phy_in_cc2_p/n   in   CC2 comparator pair
//   phy_out_en       out  CC driver enable
//   phy_out_cc1/2    out  CC driver data
//   phy_debug_cc1/2  out  synchronized CC levels
// ---------------------------------------------------------------------------
module usb_pd_cc_line
    import usb_pd_pkg::*;
#(
    parameter int system_khz = 30000,
    parameter int LOCK_EDGES = 32
) (
    input  logic clock,
    input  logic nrst,
    input  logic cc_check,
    input  logic cc_io_ctrl,
    input  logic cc_dout,
    output logic cc_lock,
    output logic cc_din,
    input  logic phy_in_cc1_p,
    input  logic phy_in_cc1_n,
    input  logic phy_in_cc2_p,
    input  logic phy_in_cc2_n,
    output logic phy_out_en,
    output logic phy_out_cc1,
    output logic phy_out_cc2,
    output logic phy_debug_cc1,
    output logic phy_debug_cc2
);

    localparam int GAP_TIMEOUT = gap_timeout_cycles(system_khz);

    cc_sel_t sel;
    logic    check_d;
    logic    rearm;
    logic    det_run;
    logic    lvl1;
    logic    lvl2;
    logic    qual1;
    logic    qual2;

    // Detection only runs while asked for, not yet locked, and not while
    // our own transmitter is driving the line.
    assign rearm   = cc_check & ~check_d;
    assign det_run = cc_check & ~cc_lock & ~cc_io_ctrl;

    cc_chan_det #(
        .GAP_TIMEOUT (GAP_TIMEOUT),
        .LOCK_EDGES  (LOCK_EDGES)
    ) u_det_cc1 (
        .clock     (clock),
        .nrst      (nrst),
        .phy_p     (phy_in_cc1_p),
        .phy_n     (phy_in_cc1_n),
        .det_run   (det_run),
        .det_clear (rearm),
        .lvl       (lvl1),
        .qualified (qual1)
    );

    cc_chan_det #(
        .GAP_TIMEOUT (GAP_TIMEOUT),
        .LOCK_EDGES  (LOCK_EDGES)
    ) u_det_cc2 (
        .clock     (clock),
        .nrst      (nrst),
        .phy_p     (phy_in_cc2_p),
        .phy_n     (phy_in_cc2_n),
        .det_run   (det_run),
        .det_clear (rearm),
        .lvl       (lvl2),
        .qualified (qual2)
    );

    // Lock arbitration. A fresh cc_check request drops an old lock; once
    // locked the choice is sticky until the next request. CC1 wins a tie.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            check_d <= 1'b0;
            cc_lock <= 1'b0;
            sel     <= CC_SEL_CC1;
        end else begin
            check_d <= cc_check;
            if (rearm) begin
                cc_lock <= 1'b0;
            end else if (!cc_lock && (qual1 || qual2)) begin
                cc_lock <= 1'b1;
                sel     <= qual1 ? CC_SEL_CC1 : CC_SEL_CC2;
            end
        end
    end

    // Registered receive and transmit steering. Nothing reaches the BMC
    // reader or the pins unless a channel is locked.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            cc_din      <= 1'b0;
            phy_out_en  <= 1'b0;
            phy_out_cc1 <= 1'b0;
            phy_out_cc2 <= 1'b0;
        end else begin
            cc_din      <= cc_lock & ((sel == CC_SEL_CC2) ? lvl2 : lvl1);
            phy_out_en  <= cc_io_ctrl & cc_lock;
            phy_out_cc1 <= cc_dout & cc_lock & (sel == CC_SEL_CC1);
            phy_out_cc2 <= cc_dout & cc_lock & (sel == CC_SEL_CC2);
        end
    end

    assign phy_debug_cc1 = lvl1;
    assign phy_debug_cc2 = lvl2;

endmodule

// File: tb/tb_usb_pd_cc_line.sv
// ---------------------------------------------------------------------------
// tb_usb_pd_cc_line
// Self-checking bench for usb_pd_cc_line (default build, no glitch filter).
// Expected values come from the externally visible rules: a pin level shows
// up on phy_debug two edges after it is sampled and on cc_din three edges
// after; lock follows the 32nd in-time toggle by four edges; toggles more
// than 121 cycles apart never accumulate.
// ---------------------------------------------------------------------------
module tb_usb_pd_cc_line;

    logic clock = 1'b0;
    logic nrst;
    logic cc_check;
    logic cc_io_ctrl;
    logic cc_dout;
    logic cc_lock;
    logic cc_din;
    logic phy_in_cc1_p;
    logic phy_in_cc1_n;
    logic phy_in_cc2_p;
    logic phy_in_cc2_n;
    logic phy_out_en;
    logic phy_out_cc1;
    logic phy_out_cc2;
    logic phy_debug_cc1;
    logic phy_debug_cc2;

    int   tests    = 0;
    int   failures = 0;

    // Decided level of each channel as the design should see it, and the
    // history of that level at every sampling edge.
    logic raw1 = 1'b0;
    logic raw2 = 1'b0;
    logic hist1[$];
    logic hist2[$];

    usb_pd_cc_line dut (
        .clock         (clock),
        .nrst          (nrst),
        .cc_check      (cc_check),
        .cc_io_ctrl    (cc_io_ctrl),
        .cc_dout       (cc_dout),
        .cc_lock       (cc_lock),
        .cc_din        (cc_din),
        .phy_in_cc1_p  (phy_in_cc1_p),
        .phy_in_cc1_n  (phy_in_cc1_n),
        .phy_in_cc2_p  (phy_in_cc2_p),
        .phy_in_cc2_n  (phy_in_cc2_n),
        .phy_out_en    (phy_out_en),
        .phy_out_cc1   (phy_out_cc1),
        .phy_out_cc2   (phy_out_cc2),
        .phy_debug_cc1 (phy_debug_cc1),
        .phy_debug_cc2 (phy_debug_cc2)
    );

    always #5 clock = ~clock;

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Drive both comparator pairs; an undecided pair (p == n) keeps the
    // previously decided level.
    task automatic applyStimulus(input logic p1, input logic n1, input logic p2, input logic n2);
        phy_in_cc1_p = p1;
        phy_in_cc1_n = n1;
        phy_in_cc2_p = p2;
        phy_in_cc2_n = n2;
        if (p1 != n1) raw1 = p1;
        if (p2 != n2) raw2 = p2;
    endtask

    task automatic step();
        @(posedge clock);
        hist1.push_back(raw1);
        hist2.push_back(raw2);
        #1;
    endtask

    task automatic rearm();
        cc_check = 1'b0;
        step();
        cc_check = 1'b1;
        step();
    endtask

    // Toggle the enabled channels 'count' times, 'period' cycles apart.
    task automatic run_toggles(input bit on1, input bit on2, input int period, input int count,
                               input bit expect_lock, input bit track_din, input bit din_sel);
        logic p1, n1, p2, n2;
        int   k;
        for (int e = 0; e < count; e++) begin
            if (on1) begin p1 = ~raw1; n1 = raw1; end
            else begin p1 = 1'($urandom_range(0, 1)); n1 = p1; end
            if (on2) begin p2 = ~raw2; n2 = raw2; end
            else begin p2 = 1'($urandom_range(0, 1)); n2 = p2; end
            applyStimulus(p1, n1, p2, n2);
            for (int s = 0; s < period; s++) begin
                step();
                if (expect_lock && e == count - 1 && s == 2)
                    checkOutput("lock_not_early", cc_lock, 1'b0);
                if (expect_lock && e == count - 1 && s == 3)
                    checkOutput("lock_on_time", cc_lock, 1'b1);
                if (track_din) begin
                    k = hist1.size() - 1;
                    checkOutput("cc_din_delay", cc_din, din_sel ? hist2[k-2] : hist1[k-2]);
                    checkOutput("debug_cc1", phy_debug_cc1, hist1[k-1]);
                    checkOutput("debug_cc2", phy_debug_cc2, hist2[k-1]);
                end
            end
        end
        if (!expect_lock && !track_din)
            checkOutput("no_lock", cc_lock, 1'b0);
    endtask

    // Transmit a pattern starting 1,0,1 and expect it on the selected pin.
    task automatic transmit(input bit exp_sel, input int nbits);
        logic d;
        cc_io_ctrl = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            d = (i < 3) ? (i != 1) : 1'($urandom_range(0, 1));
            cc_dout = d;
            step();
            checkOutput("tx_en", phy_out_en, 1'b1);
            checkOutput("tx_cc1", phy_out_cc1, exp_sel ? 1'b0 : d);
            checkOutput("tx_cc2", phy_out_cc2, exp_sel ? d : 1'b0);
            checkOutput("tx_lock_held", cc_lock, 1'b1);
        end
        cc_io_ctrl = 1'b0;
        cc_dout    = 1'b0;
        step();
        checkOutput("tx_en_off", phy_out_en, 1'b0);
    endtask

    initial begin
        int period;
        logic a, b;

        nrst       = 1'b0;
        cc_check   = 1'b0;
        cc_io_ctrl = 1'b0;
        cc_dout    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset with pins toggling: every output stays low.
        for (int i = 0; i < 6; i++) begin
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            applyStimulus(a, ~a, b, ~b);
            cc_dout = 1'($urandom_range(0, 1));
            step();
            checkOutput("rst_lock", cc_lock, 1'b0);
            checkOutput("rst_din", cc_din, 1'b0);
            checkOutput("rst_en", phy_out_en, 1'b0);
            checkOutput("rst_out1", phy_out_cc1, 1'b0);
            checkOutput("rst_out2", phy_out_cc2, 1'b0);
            checkOutput("rst_dbg1", phy_debug_cc1, 1'b0);
            checkOutput("rst_dbg2", phy_debug_cc2, 1'b0);
        end
        phy_in_cc1_p = 1'b0; phy_in_cc1_n = 1'b0;
        phy_in_cc2_p = 1'b0; phy_in_cc2_n = 1'b0;
        raw1 = 1'b0;
        raw2 = 1'b0;
        cc_dout = 1'b0;
        nrst = 1'b1;
        step();
        checkOutput("post_rst_lock", cc_lock, 1'b0);

        // CC2 preamble locks CC2; cc_din and debug follow CC2.
        cc_check = 1'b1;
        step();
        period = $urandom_range(40, 115);
        run_toggles(1'b0, 1'b1, period, 32, 1'b1, 1'b0, 1'b0);
        run_toggles(1'b0, 1'b1, period, 6, 1'b0, 1'b1, 1'b1);
        transmit(1'b1, 6);

        // Sticky while cc_check is low, cleared by a new request.
        cc_check = 1'b0;
        step();
        checkOutput("lock_sticky", cc_lock, 1'b1);
        cc_check = 1'b1;
        step();
        checkOutput("rearm_clear", cc_lock, 1'b0);
        step();
        checkOutput("din_unlocked", cc_din, 1'b0);

        // Edges too far apart never lock, including right at the boundary.
        run_toggles(1'b1, 1'b0, $urandom_range(140, 170), 40, 1'b0, 1'b0, 1'b0);
        rearm();
        run_toggles(1'b1, 1'b0, 122, 40, 1'b0, 1'b0, 1'b0);
        rearm();
        run_toggles(1'b1, 1'b0, 121, 32, 1'b1, 1'b0, 1'b0);
        transmit(1'b0, 4);

        // Both channels qualify together: CC1 wins.
        rearm();
        run_toggles(1'b1, 1'b1, $urandom_range(40, 115), 32, 1'b1, 1'b0, 1'b0);
        transmit(1'b0, 5);

        // Own transmission must not lock; counting resumes afterwards.
        cc_io_ctrl = 1'b1;
        rearm();
        period = $urandom_range(40, 115);
        run_toggles(1'b1, 1'b0, period, 40, 1'b0, 1'b0, 1'b0);
        checkOutput("freeze_en", phy_out_en, 1'b0);
        cc_io_ctrl = 1'b0;
        run_toggles(1'b1, 1'b0, period, 32, 1'b1, 1'b0, 1'b0);

        // Reset while locked drops the lock on the next clock.
        nrst = 1'b0;
        step();
        checkOutput("midrst_lock", cc_lock, 1'b0);
        checkOutput("midrst_din", cc_din, 1'b0);
        nrst = 1'b1;
        step();
        checkOutput("midrst_post", cc_lock, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
